// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
//   Shared definitions for the demux12 router and its mux21 counterpart.
//   - state_t : PASS / HOLD encoding of the routing state machine
//   - DEST_0/DEST_1 : destination encoding taken from the word's class bit
//   - DEMUX_DATA_SIZE : default word width shared with mux21
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package demux_pkg;

  localparam int DEMUX_DATA_SIZE = 10;

  typedef enum logic [0:0] {
    ST_PASS = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic DEST_0 = 1'b0;
  localparam logic DEST_1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/push_counter.sv
// ---------------------------------------------------------------------------
// push_counter
//   Free-running wrap-around event counter. Increments by one on every
//   clock edge where i_en is high; wraps from all-ones to zero silently.
//   Ports:
//     clk      in   clock
//     rst_n    in   asynchronous active-low reset (count -> 0)
//     i_en     in   count enable
//     o_count  out  current count, WIDTH bits
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module push_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/demux12.sv
// ---------------------------------------------------------------------------
// demux12
//   1:2 routing demultiplexer. Each accepted word is routed by its class bit
//   (in[SEL_BIT]) to FIFO 0 or FIFO 1. If the destination FIFO is almost
//   full at the accept edge, the word is parked in a one-entry hold register
//   and ready is dropped until that FIFO can take it.
//   Ports:
//     clk                    in   clock, rising edge
//     reset                  in   asynchronous active-low reset
//     in[DATA_SIZE]          in   word from upstream
//     valid_in               in   in carries a word
//     fifo_down0_almostfull  in   FIFO 0 cannot take more words
//     fifo_down1_almostfull  in   FIFO 1 cannot take more words
//     ready                  out  word accepted this cycle if valid_in
//     out0/out1[DATA_SIZE]   out  write data to FIFO 0 / FIFO 1
//     push_0/push_1          out  one-cycle write strobes
//     push_count0/1[CNT_SIZE]out  wrap-around push totals per FIFO
//   All outputs are registered or decoded from state only.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module demux12
  import demux_pkg::*;
#(
  parameter int DATA_SIZE = DEMUX_DATA_SIZE,
  parameter int SEL_BIT   = DATA_SIZE - 1,
  parameter int CNT_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] in,
  input  logic                 valid_in,
  input  logic                 fifo_down0_almostfull,
  input  logic                 fifo_down1_almostfull,
  output logic                 ready,
  output logic [DATA_SIZE-1:0] out0,
  output logic [DATA_SIZE-1:0] out1,
  output logic                 push_0,
  output logic                 push_1,
  output logic [CNT_SIZE-1:0]  push_count0,
  output logic [CNT_SIZE-1:0]  push_count1
);

  state_t               r_state;
  state_t               w_state_nxt;

  logic [DATA_SIZE-1:0] r_hold_word;
  logic                 r_hold_dest;

  logic [DATA_SIZE-1:0] r_out0;
  logic [DATA_SIZE-1:0] r_out1;
  logic                 r_push0;
  logic                 r_push1;

  logic                 w_dest;
  logic                 w_af_in;
  logic                 w_af_hold;
  logic                 w_accept;

  logic                 w_push0_nxt;
  logic                 w_push1_nxt;
  logic [DATA_SIZE-1:0] w_word_nxt;
  logic                 w_load_hold;

  // Only the selected FIFO's almost-full matters; the other is ignored.
  assign w_dest    = in[SEL_BIT];
  assign w_af_in   = (w_dest == DEST_1) ? fifo_down1_almostfull : fifo_down0_almostfull;
  assign w_af_hold = (r_hold_dest == DEST_1) ? fifo_down1_almostfull : fifo_down0_almostfull;
  assign w_accept  = valid_in && (r_state == ST_PASS);

  // -------------------------------------------------------------------------
  // Next-state / push decision
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_push0_nxt = 1'b0;
    w_push1_nxt = 1'b0;
    w_word_nxt  = in;
    w_load_hold = 1'b0;

    case (r_state)
      ST_PASS: begin
        if (w_accept) begin
          if (!w_af_in) begin
            w_push0_nxt = (w_dest == DEST_0);
            w_push1_nxt = (w_dest == DEST_1);
          end else begin
            w_load_hold = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Push the parked word as soon as its FIFO frees up; returning to
        // PASS in the same edge lets the next word be accepted immediately.
        if (!w_af_hold) begin
          w_word_nxt  = r_hold_word;
          w_push0_nxt = (r_hold_dest == DEST_0);
          w_push1_nxt = (r_hold_dest == DEST_1);
          w_state_nxt = ST_PASS;
        end
      end
      default: begin
        w_state_nxt = ST_PASS;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, hold register and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_PASS;
      r_hold_word <= '0;
      r_hold_dest <= DEST_0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_hold) begin
        r_hold_word <= in;
        r_hold_dest <= w_dest;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out0  <= '0;
      r_out1  <= '0;
      r_push0 <= 1'b0;
      r_push1 <= 1'b0;
    end else begin
      r_push0 <= w_push0_nxt;
      r_push1 <= w_push1_nxt;
      if (w_push0_nxt) begin
        r_out0 <= w_word_nxt;
      end
      if (w_push1_nxt) begin
        r_out1 <= w_word_nxt;
      end
    end
  end

  // Counters advance on the same edge that raises the strobe, so the count
  // seen alongside a push already includes that push.
  push_counter #(
    .WIDTH (CNT_SIZE)
  ) u_cnt0 (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (w_push0_nxt),
    .o_count (push_count0)
  );

  push_counter #(
    .WIDTH (CNT_SIZE)
  ) u_cnt1 (
    .clk     (clk),
    .rst_n   (reset),
    .i_en    (w_push1_nxt),
    .o_count (push_count1)
  );

  assign ready  = (r_state == ST_PASS);
  assign out0   = r_out0;
  assign out1   = r_out1;
  assign push_0 = r_push0;
  assign push_1 = r_push1;

endmodule

`default_nettype wire

// File: tb/tb_demux12.sv
// ---------------------------------------------------------------------------
// tb_demux12
//   Scoreboard bench for demux12: stimulus enqueues the expected push
//   (destination, word, count after push); a monitor pops and compares on
//   every push strobe.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_demux12;

  localparam int DW = 10;
  localparam int CW = 8;

  typedef struct packed {
    logic          dest;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in;
  logic          valid_in;
  logic          af0;
  logic          af1;
  logic          ready;
  logic [DW-1:0] out0;
  logic [DW-1:0] out1;
  logic          push_0;
  logic          push_1;
  logic [CW-1:0] push_count0;
  logic [CW-1:0] push_count1;

  exp_t          q[$];
  int            errors;
  int            checks;
  logic [CW-1:0] exp_cnt0;
  logic [CW-1:0] exp_cnt1;
  logic          pend_valid;
  logic          pend_dest;
  logic [DW-1:0] pend_word;

  demux12 #(
    .DATA_SIZE (DW),
    .SEL_BIT   (DW-1),
    .CNT_SIZE  (CW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .in                    (in),
    .valid_in              (valid_in),
    .fifo_down0_almostfull (af0),
    .fifo_down1_almostfull (af1),
    .ready                 (ready),
    .out0                  (out0),
    .out1                  (out1),
    .push_0                (push_0),
    .push_1                (push_1),
    .push_count0           (push_count0),
    .push_count1           (push_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_push(input logic dest, input logic [DW-1:0] word);
    exp_t e;
    if (dest) exp_cnt1 = exp_cnt1 + 8'd1;
    else      exp_cnt0 = exp_cnt0 + 8'd1;
    e.dest = dest;
    e.data = word;
    e.cnt  = dest ? exp_cnt1 : exp_cnt0;
    q.push_back(e);
  endtask

  // Present a word and keep valid_in high; returns after the accept edge.
  task automatic send(input logic [DW-1:0] word);
    int  n;
    logic af;
    in       = word;
    valid_in = 1'b1;
    n = 0;
    while (!ready && n < 20) begin
      cyc();
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", {31'd0, ready}, 32'd1);
    end else begin
      af = word[DW-1] ? af1 : af0;
      if (!af) begin
        expect_push(word[DW-1], word);
      end else begin
        pend_valid = 1'b1;
        pend_dest  = word[DW-1];
        pend_word  = word;
      end
      cyc();
    end
  endtask

  // Monitor: compare every presented push against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (push_0 && push_1) begin
        chk("both_strobes", 32'd1, 32'd0);
      end
      if (push_0 || push_1) begin
        if (q.size() == 0) begin
          chk("unexpected_push", {30'd0, push_1, push_0}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("push_dest", {31'd0, push_1}, {31'd0, e.dest});
          chk("push_data", {22'd0, (push_1 ? out1 : out0)}, {22'd0, e.data});
          chk("push_cnt", {24'd0, (push_1 ? push_count1 : push_count0)}, {24'd0, e.cnt});
        end
      end
    end
  end

  initial begin
    errors     = 0;
    checks     = 0;
    exp_cnt0   = '0;
    exp_cnt1   = '0;
    pend_valid = 1'b0;
    pend_dest  = 1'b0;
    pend_word  = '0;
    reset      = 1'b0;
    in         = 10'h155;
    valid_in   = 1'b1;
    af0        = 1'b0;
    af1        = 1'b0;

    // Reset held with valid_in high: no pushes, ready high, outputs zero.
    repeat (3) begin
      cyc();
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_push", {30'd0, push_1, push_0}, 32'd0);
      chk("rst_out", {12'd0, out1, out0}, 32'd0);
      chk("rst_cnt", {16'd0, push_count1, push_count0}, 32'd0);
    end
    valid_in = 1'b0;
    reset    = 1'b1;
    cyc();

    // Back-to-back pass-through to both FIFOs.
    send(10'h155);
    send(10'h2AA);
    valid_in = 1'b0;
    cyc();
    cyc();
    chk("pt_cnt", {16'd0, push_count1, push_count0}, {16'd0, 8'd1, 8'd1});
    chk("pt_ready", {31'd0, ready}, 32'd1);

    // Stall on FIFO 1; a competing word while stalled must not be taken.
    af1 = 1'b1;
    send(10'h3FF);
    chk("stall_ready0", {31'd0, ready}, 32'd0);
    in       = 10'h0AA;
    valid_in = 1'b1;
    repeat (3) begin
      cyc();
      chk("stall_hold_ready", {31'd0, ready}, 32'd0);
    end
    af1      = 1'b0;
    valid_in = 1'b0;
    expect_push(pend_dest, pend_word);
    pend_valid = 1'b0;
    cyc();
    chk("stall_release_ready", {31'd0, ready}, 32'd1);
    cyc();
    chk("stall_cnt", {16'd0, push_count1, push_count0}, {16'd0, 8'd2, 8'd1});

    // FIFO 1 almost-full must not affect words for FIFO 0.
    af1 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("iso_ready", {31'd0, ready}, 32'd1);
      send(DW'(i));
    end
    valid_in = 1'b0;
    cyc();
    cyc();
    chk("iso_cnt0", {24'd0, push_count0}, 32'd6);
    af1 = 1'b0;

    // Reset in the middle of HOLD discards the parked word.
    af0 = 1'b1;
    send(10'h0F0);
    valid_in = 1'b0;
    cyc();
    chk("rh_ready0", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    #1;
    pend_valid = 1'b0;
    exp_cnt0   = '0;
    exp_cnt1   = '0;
    chk("rh_ready", {31'd0, ready}, 32'd1);
    chk("rh_cnt", {16'd0, push_count1, push_count0}, 32'd0);
    chk("rh_out", {12'd0, out1, out0}, 32'd0);
    af0 = 1'b0;
    cyc();
    reset = 1'b1;
    repeat (3) cyc();
    chk("rh_cnt_after", {16'd0, push_count1, push_count0}, 32'd0);

    // Counter wrap on FIFO 0 while FIFO 1 count stays put.
    send(10'h201);
    for (int i = 0; i < 256; i++) begin
      send(DW'(i & 9'h1FF));
    end
    valid_in = 1'b0;
    cyc();
    cyc();
    chk("wrap_cnt0", {24'd0, push_count0}, 32'd0);
    chk("wrap_cnt1", {24'd0, push_count1}, 32'd1);

    repeat (3) cyc();
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux12.md
# demux12

1:2 routing demultiplexer for the PCIe switching datapath; the transmit-side counterpart of the `mux21` arbiter. It accepts one word stream from the upstream mux stage (`in`/`valid_in`), selects a destination from a class bit in each word, and pushes the word into one of two downstream FIFOs. When the destination FIFO's almost-full flag is set, it holds the word in a one-entry stall register and deasserts `ready` toward the upstream stage until the word drains.

## Interface
- `DATA_SIZE`, 10, word width in bits.
- `SEL_BIT`, `DATA_SIZE-1`, bit index of the class bit: 0 routes to FIFO 0, 1 routes to FIFO 1.
- `CNT_SIZE`, 8, width of the per-destination push counters.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `in`  in  DATA_SIZE  word from the upstream stage.
- `valid_in`  in  1  `in` carries a word this cycle.
- `fifo_down0_almostfull`  in  1  FIFO 0 cannot take more words.
- `fifo_down1_almostfull`  in  1  FIFO 1 cannot take more words.
- `ready`  out  1  demux accepts a word this cycle.
- `out0`  out  DATA_SIZE  write data to FIFO 0.
- `out1`  out  DATA_SIZE  write data to FIFO 1.
- `push_0`  out  1  write strobe to FIFO 0.
- `push_1`  out  1  write strobe to FIFO 1.
- `push_count0`  out  CNT_SIZE  total words pushed to FIFO 0.
- `push_count1`  out  CNT_SIZE  total words pushed to FIFO 1.

## Operation
- **Accept:** a word is accepted on the edge where `valid_in && ready`. If `valid_in` is high while `ready` is low, the word is ignored. Upstream must hold the word until `ready` is high.
- **Destination:** `dest = in[SEL_BIT]`. The full word, class bit included, is forwarded unchanged.
- **State machine:** two states, PASS (reset state) and HOLD.
  - PASS, accept, `almostfull[dest]` low: on the next cycle `push_dest=1` and `out_dest=word`. Stay in PASS.
  - PASS, accept, `almostfull[dest]` high: load the word and `dest` into the hold register and go to HOLD.
  - HOLD: `ready=0`. Each cycle, sample `almostfull[held_dest]`. When it is low, push the held word on the next cycle and return to PASS.
  - The almost-full flag of the non-selected FIFO is ignored throughout.
- **`ready`:** Moore output; 1 in PASS, 0 in HOLD. `ready` is also 1 on the cycle in which the held word is pushed.
- **Strobes:** `push_0` and `push_1` are never high in the same cycle. Each strobe is high for exactly one cycle per word.
- **Data outputs:** `out0`/`out1` update only on their own push and otherwise keep their last value.
- **Counters:** `push_countN` increments on every `push_N`. It wraps from 2^CNT_SIZE-1 to 0 with no saturation or flag.
- **Reset (asynchronous, any time, including while in HOLD):**
  - state returns to PASS;
  - any held word is discarded;
  - `out0`, `out1`, `push_0`, `push_1` and both counters go to 0;
  - `ready` goes to 1.

## Timing
- Latency from accept to push is 1 cycle when the destination is not almost-full.
- Throughput is one word per cycle in PASS, including back-to-back words alternating between destinations.
- A stall costs at least 1 accept slot. If almost-full drops at cycle K while in HOLD, the push occurs at K+1 and the next accept can occur at K+1.
- No combinational path from any input to any output. `ready` depends on state only.
- Almost-full is sampled on the accept edge. Once a word has been pushed, a later rise of almost-full does not recall it.

## Structure
- Shared package `demux_pkg`:
  - state encoding constants `ST_PASS`/`ST_HOLD`;
  - destination encoding `DEST_0=1'b0`, `DEST_1=1'b1`;
  - default `DATA_SIZE`, shared with `mux21`.
- A single flat module. The one natural sub-module is `push_counter` (parameterised width, enable, async active-low reset), instantiated twice.
- A gate-level `demux12_syn` is produced by the usual synthesis flow and compared against the behavioural model in the testbench.

## Test plan
- **Reset:** hold `reset=0` for 3 cycles with `valid_in=1` -> all outputs 0, `ready=1`, no push.
- **Pass-through:** `in=10'h155` (bit 9 = 0), then `in=10'h2AA` (bit 9 = 1), back-to-back, both almost-fulls low -> `push_0` with `out0=0x155` at N+1, `push_1` with `out1=0x2AA` at N+2, counters 1/1.
- **Stall:** `fifo_down1_almostfull=1`, send `0x3FF` -> `ready=0` from the next cycle. Hold almost-full for 4 cycles, then drop it -> `push_1` with `0x3FF` one cycle later, `ready=1`. Meanwhile, words on `in` while `ready=0` are not pushed.
- **Isolation:** `fifo_down1_almostfull=1` throughout, stream 5 words with bit 9 = 0 -> 5 consecutive `push_0`, `ready` stays 1.
- **Reset during HOLD:** pulse `reset` low mid-HOLD -> held word never pushed, counters 0, `ready=1`.
- **Counter wrap:** push 256 words to FIFO 0 -> `push_count0=0`, `push_count1` unchanged. Throughout every scenario, behavioural and synthesised outputs match on every cycle.
